// File: rtl/multicycle_control.sv
// Multi-cycle processor control FSM: fetch, decode, execute, memory access and write-back sequencing.
// Optional MEM_TIMEOUT_EN adds a bounded memReady wait that traps once TIMEOUT_CYCLES wait cycles have elapsed.

// state     | meaning
// FETCH     | wait for instrValid, latch opcode fields
// DECODE    | PC+4, classify instruction type
// EXECUTE   | ALU op / address calc / branch compare
// MEMACCESS | hold load/store strobe until memReady
// WRITEBACK | one-cycle register file write
// TRAP      | unknown opcode or memory timeout, held until reset
module multicycle_control #(
    parameter int ALUOP_W = 5
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic [31:0]        instruction,
    input  logic               instrValid,
    input  logic               memReady,
    input  logic               aluZero,
    output logic               irWrite,
    output logic               enablePC,
    output logic               branch,
    output logic               memRead,
    output logic               memWrite,
    output logic               memToReg,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ALUSrc,
    output logic               regWrite,
    output logic               illegal,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMACCESS = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd7
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    logic [8:0] ir_q;        // instruction[31:23]
    logic       timed_out;

    logic [2:0] ir_type;
    logic       is_alu;
    logic       is_br;
    logic       is_mem;
    logic       is_store;
    logic       unused_bits;

    assign ir_type     = ir_q[8:6];
    assign is_alu      = (ir_type == 3'b001);
    assign is_br       = (ir_type == 3'b010);
    assign is_mem      = (ir_type == 3'b100);
    assign is_store    = ir_q[1];
    assign unused_bits = ^instruction[22:0];
    assign state       = cur_state;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cur_state <= S_FETCH;
            ir_q      <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_FETCH && instrValid) begin
                ir_q <= instruction[31:23];
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside MEMACCESS, so every access starts from a clean count.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wait_cnt <= '0;
        end else if (cur_state != S_MEMACCESS) begin
            wait_cnt <= '0;
        end else if (!memReady) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timed_out = (cur_state == S_MEMACCESS) && !memReady
                       && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        nxt_state = cur_state;
        irWrite   = 1'b0;
        enablePC  = 1'b0;
        branch    = 1'b0;
        memRead   = 1'b1;
        memWrite  = 1'b1;
        memToReg  = 1'b0;
        ALUOp     = '0;
        ALUSrc    = 1'b0;
        regWrite  = 1'b0;
        illegal   = 1'b0;

        case (cur_state)
            S_FETCH: begin
                irWrite = instrValid;
                if (instrValid) begin
                    nxt_state = S_DECODE;
                end
            end

            S_DECODE: begin
                enablePC = 1'b1;
                if (is_alu || is_br || is_mem) begin
                    nxt_state = S_EXECUTE;
                end else begin
                    nxt_state = S_TRAP;
                end
            end

            S_EXECUTE: begin
                if (is_alu) begin
                    ALUOp     = ALUOP_W'(ir_q[5:1]);
                    ALUSrc    = ir_q[0];
                    nxt_state = S_WRITEBACK;
                end else if (is_mem) begin
                    ALUSrc    = 1'b1;
                    nxt_state = S_MEMACCESS;
                end else if (is_br) begin
                    ALUOp     = ALUOP_W'(1);
                    branch    = aluZero;
                    enablePC  = aluZero;
                    nxt_state = S_FETCH;
                end else begin
                    nxt_state = S_TRAP;
                end
            end

            S_MEMACCESS: begin
                ALUSrc   = 1'b1;
                memRead  = is_store;
                memWrite = !is_store;
                // memReady on the limit cycle still completes the access
                if (memReady) begin
                    nxt_state = is_store ? S_FETCH : S_WRITEBACK;
                end else if (timed_out) begin
                    nxt_state = S_TRAP;
                end
            end

            S_WRITEBACK: begin
                regWrite = 1'b1;
                memToReg = is_mem;
                if (is_mem) begin
                    ALUSrc = 1'b1;
                end else begin
                    ALUOp  = ALUOP_W'(ir_q[5:1]);
                    ALUSrc = ir_q[0];
                end
                nxt_state = S_FETCH;
            end

            S_TRAP: begin
                illegal = 1'b1;
            end

            default: begin
                nxt_state = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected cycle traces built from the
// instruction-level rules, checked every cycle, plus directed literal checks on strobe counts and state traces.
module tb_multicycle_control;

    localparam int ALUOP_W = 5;
`ifdef MEM_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic               clock = 1'b0;
    logic               resetN = 1'b0;
    logic [31:0]        instruction = '0;
    logic               instrValid = 1'b0;
    logic               memReady = 1'b0;
    logic               aluZero = 1'b0;
    logic               irWrite, enablePC, branch, memRead, memWrite, memToReg;
    logic [ALUOP_W-1:0] ALUOp;
    logic               ALUSrc, regWrite, illegal;
    logic [2:0]         state;

    multicycle_control #(.ALUOP_W(ALUOP_W)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .instruction(instruction),
        .instrValid (instrValid),
        .memReady   (memReady),
        .aluZero    (aluZero),
        .irWrite    (irWrite),
        .enablePC   (enablePC),
        .branch     (branch),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memToReg   (memToReg),
        .ALUOp      (ALUOp),
        .ALUSrc     (ALUSrc),
        .regWrite   (regWrite),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic       irw, epc, br, mrd, mwr, m2r;
        logic [4:0] aop;
        logic       asrc, rw, ill, chk_op;
    } exp_t;

    exp_t        q[$];
    exp_t        ce;
    bit          model_on = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          rd_low, wr_low, rw_cnt, pc_cnt, br_cnt, ill_cnt, m2r_cnt, trace_len;
    logic [31:0] trace_code;
    logic [4:0]  exec_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (model_on) begin
            trace_code = {trace_code[27:0], 1'b0, state};
            trace_len++;
            if (!memRead)  rd_low++;
            if (!memWrite) wr_low++;
            if (regWrite)  rw_cnt++;
            if (enablePC)  pc_cnt++;
            if (branch)    br_cnt++;
            if (illegal)   ill_cnt++;
            if (memToReg)  m2r_cnt++;
            if (state == 3'd2) exec_op = ALUOp;
            chk("strobe_excl", 32'(!memRead && !memWrite), 32'd0);
            if (q.size() > 0) begin
                ce = q.pop_front();
                chk("state", 32'(state), 32'(ce.st));
                chk("irWrite", 32'(irWrite), 32'(ce.irw));
                chk("enablePC", 32'(enablePC), 32'(ce.epc));
                chk("branch", 32'(branch), 32'(ce.br));
                chk("memRead", 32'(memRead), 32'(ce.mrd));
                chk("memWrite", 32'(memWrite), 32'(ce.mwr));
                chk("memToReg", 32'(memToReg), 32'(ce.m2r));
                chk("regWrite", 32'(regWrite), 32'(ce.rw));
                chk("illegal", 32'(illegal), 32'(ce.ill));
                if (ce.chk_op) begin
                    chk("ALUOp", 32'(ALUOp), 32'(ce.aop));
                    chk("ALUSrc", 32'(ALUSrc), 32'(ce.asrc));
                end
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t ex(input logic [2:0] st);
        exp_t e;
        e        = '0;
        e.st     = st;
        e.mrd    = 1'b1;
        e.mwr    = 1'b1;
        e.chk_op = 1'b1;
        e.ill    = (st == 3'd7);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0:       r[31:29] = 3'b001;
            1:       r[31:29] = 3'b010;
            default: r[31:29] = 3'b100;
        endcase
        return r;
    endfunction

    task automatic step(input logic iv, input logic [31:0] ins, input logic mr, input logic az,
                        input exp_t e);
        @(posedge clock);
        #1;
        instrValid  = iv;
        instruction = ins;
        memReady    = mr;
        aluZero     = az;
        q.push_back(e);
    endtask

    task automatic clr();
        rd_low = 0; wr_low = 0; rw_cnt = 0; pc_cnt = 0; br_cnt = 0;
        ill_cnt = 0; m2r_cnt = 0; trace_len = 0; trace_code = '0; exec_op = '1;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset(input bit check_now);
        model_on   = 1'b0;
        q.delete();
        resetN     = 1'b0;
        instrValid = 1'b0;
        memReady   = 1'b0;
        #1;
        if (check_now) begin
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_memRead", 32'(memRead), 32'd1);
            chk("rst_memWrite", 32'(memWrite), 32'd1);
            chk("rst_regWrite", 32'(regWrite), 32'd0);
            chk("rst_illegal", 32'(illegal), 32'd0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        resetN   = 1'b1;
        model_on = 1'b1;
    endtask

    // One instruction: idle fetch cycles, then the cycle-by-cycle outputs the instruction type dictates.
    task automatic run_instr(input logic [31:0] ins, input int w, input logic z, input int idle);
        logic [2:0] typ;
        exp_t       e;
        typ = ins[31:29];
        for (int i = 0; i < idle; i++) step(1'b0, $urandom, rb(), rb(), ex(3'd0));
        e = ex(3'd0); e.irw = 1'b1;
        step(1'b1, ins, rb(), rb(), e);
        e = ex(3'd1); e.epc = 1'b1;
        step(rb(), $urandom, rb(), rb(), e);
        if (typ != 3'd1 && typ != 3'd2 && typ != 3'd4) begin
            for (int i = 0; i < 20; i++) step(rb(), $urandom, rb(), rb(), ex(3'd7));
            return;
        end
        e = ex(3'd2);
        if (typ == 3'd1) begin
            e.aop = ins[28:24]; e.asrc = ins[23];
        end else if (typ == 3'd4) begin
            e.asrc = 1'b1;
        end else begin
            e.aop = 5'd1; e.br = z; e.epc = z;
        end
        step(rb(), $urandom, rb(), (typ == 3'd2) ? z : rb(), e);
        if (typ == 3'd2) return;
        if (typ == 3'd4) begin
            int last;
            last = w;
`ifdef MEM_TIMEOUT_EN
            if (w > TO) last = TO;
`endif
            for (int i = 0; i <= last; i++) begin
                e = ex(3'd3); e.asrc = 1'b1;
                if (ins[24]) e.mwr = 1'b0;
                else         e.mrd = 1'b0;
                step(rb(), $urandom, (i == w), rb(), e);
            end
`ifdef MEM_TIMEOUT_EN
            if (w > TO) begin
                for (int i = 0; i < 5; i++) step(rb(), $urandom, rb(), rb(), ex(3'd7));
                return;
            end
`endif
            if (ins[24]) return;
        end
        e = ex(3'd4); e.rw = 1'b1;
        if (typ == 3'd4) begin
            e.m2r = 1'b1; e.chk_op = 1'b0;
        end else begin
            e.aop = ins[28:24]; e.asrc = ins[23];
        end
        step(rb(), $urandom, rb(), rb(), e);
    endtask

    initial begin
        exp_t e;
        clr();
        do_reset(1'b1);

        // ALU 2A80_0000: ALUOp 01010, immediate operand
        clr();
        run_instr(32'h2A80_0000, 0, 1'b0, 0);
        settle();
        chk("alu_trace", trace_code, 32'h0000_0124);
        chk("alu_len", 32'(trace_len), 32'd4);
        chk("alu_exec_op", 32'(exec_op), 32'h0A);
        chk("alu_rw_cnt", 32'(rw_cnt), 32'd1);
        chk("alu_m2r_cnt", 32'(m2r_cnt), 32'd0);

        // load with three wait cycles
        clr();
        run_instr(32'h8000_0000, 3, 1'b0, 0);
        settle();
        chk("ld_trace", trace_code, 32'h0123_3334);
        chk("ld_rd_low", 32'(rd_low), 32'd4);
        chk("ld_wr_low", 32'(wr_low), 32'd0);
        chk("ld_rw_cnt", 32'(rw_cnt), 32'd1);
        chk("ld_m2r_cnt", 32'(m2r_cnt), 32'd1);

        // store, memReady immediate
        clr();
        run_instr(32'h8100_0000, 0, 1'b0, 0);
        settle();
        chk("st_trace", trace_code, 32'h0000_0123);
        chk("st_wr_low", 32'(wr_low), 32'd1);
        chk("st_rw_cnt", 32'(rw_cnt), 32'd0);

        // second store interrupted by reset in MEMACCESS
        clr();
        e = ex(3'd0); e.irw = 1'b1;
        step(1'b1, 32'h8100_0000, 1'b0, 1'b0, e);
        e = ex(3'd1); e.epc = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, e);
        e = ex(3'd2); e.asrc = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, e);
        e = ex(3'd3); e.asrc = 1'b1; e.mwr = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0, e);
        step(1'b0, 32'h0, 1'b0, 1'b0, e);
        settle();
        chk("st2_wr_low", 32'(wr_low), 32'd2);
        chk("st2_memWrite_pre", 32'(memWrite), 32'd0);
        do_reset(1'b1);
        chk("st2_rw_cnt", 32'(rw_cnt), 32'd0);

        // branch taken / not taken
        clr();
        run_instr(32'h4000_0000, 0, 1'b1, 0);
        settle();
        chk("br1_trace", trace_code, 32'h0000_0012);
        chk("br1_pc_cnt", 32'(pc_cnt), 32'd2);
        chk("br1_br_cnt", 32'(br_cnt), 32'd1);
        chk("br1_exec_op", 32'(exec_op), 32'd1);
        clr();
        run_instr(32'h4000_0000, 0, 1'b0, 0);
        settle();
        chk("br0_pc_cnt", 32'(pc_cnt), 32'd1);
        chk("br0_br_cnt", 32'(br_cnt), 32'd0);

        // randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            run_instr(rand_instr(), $urandom_range(0, 4), rb(), $urandom_range(0, 2));
        end
        settle();

        // unknown type 111 traps and stays
        clr();
        run_instr(32'hE000_0000, 0, 1'b0, 0);
        settle();
        chk("trap_ill_cnt", 32'(ill_cnt), 32'd20);
        chk("trap_state", 32'(state), 32'd7);
        do_reset(1'b1);

`ifdef MEM_TIMEOUT_EN
        // memReady on the limit cycle completes normally
        clr();
        run_instr(32'h8000_0000, TO, 1'b0, 0);
        settle();
        chk("to_edge_rd_low", 32'(rd_low), 32'(TO + 1));
        chk("to_edge_rw_cnt", 32'(rw_cnt), 32'd1);
        // memReady stuck low traps
        clr();
        run_instr(32'h8000_0000, 1000, 1'b0, 0);
        settle();
        chk("to_rd_low", 32'(rd_low), 32'(TO + 1));
        chk("to_state", 32'(state), 32'd7);
        do_reset(1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
